// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//
// Two-port arbiter in front of a single-ported data RAM. Each requester
// raises a level request with its command, and the arbiter serialises the
// requests onto the RAM. A transaction always takes three states:
// IDLE (grant), ACCESS (one RAM cycle), DONE (one-cycle completion pulse).
//
// Handshake (req/done): a requester raises pN_req with pN_we/pN_addr/pN_wdata
// and holds all four stable until it sees pN_done high for one cycle. In the
// cycle after done it either drops req or presents its next request. The
// command is latched on the grant edge; later changes to the command are
// ignored until the next grant. pN_err and pN_rdata are only meaningful
// while pN_done is high and are 0 otherwise.
//
// Ports
//   clk_in               system clock, rising edge
//   reset                asynchronous, active-low reset
//   pN_req/we/addr/wdata requester N command (N = 0, 1)
//   pN_done/err/rdata    requester N completion pulse, misalignment flag, data
//   ram_rena/ram_wena    RAM read / write enables (ACCESS state only)
//   ram_addr/ram_wdata   RAM address / write data (ACCESS state only, else 0)
//   ram_rdata            RAM combinational read data
//   busy                 high whenever a transaction is in flight
//   owner                port that holds / last held the grant
//   state_dbg            current FSM state, for debug and checkers
//
// Parameters
//   ADDR_W     byte-address width
//   DATA_W     data width
//   FIXED_PRI  0 = round-robin between the ports, 1 = port 0 wins contention
// -----------------------------------------------------------------------------
module dmem_arbiter #(
   parameter int unsigned ADDR_W    = 32,
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned FIXED_PRI = 0
) (
   input  logic              clk_in,
   input  logic              reset,

   input  logic              p0_req,
   input  logic              p0_we,
   input  logic [ADDR_W-1:0] p0_addr,
   input  logic [DATA_W-1:0] p0_wdata,
   output logic              p0_done,
   output logic              p0_err,
   output logic [DATA_W-1:0] p0_rdata,

   input  logic              p1_req,
   input  logic              p1_we,
   input  logic [ADDR_W-1:0] p1_addr,
   input  logic [DATA_W-1:0] p1_wdata,
   output logic              p1_done,
   output logic              p1_err,
   output logic [DATA_W-1:0] p1_rdata,

   output logic              ram_rena,
   output logic              ram_wena,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata,

   output logic              busy,
   output logic              owner,
   output logic [1:0]        state_dbg
);

   // IDLE is encoded as 0 so that every output, including state_dbg,
   // reads 0 while reset is held.
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2
   } state_t;

   state_t              state;
   state_t              state_next;

   // Priority pointer: the port that wins when both request together.
   logic                ptr;

   logic                grant_valid;
   logic                grant_port;

   // Command latched on the grant edge.
   logic                lat_we;
   logic [ADDR_W-1:0]   lat_addr;
   logic [DATA_W-1:0]   lat_wdata;

   // Read data captured at the end of ACCESS, presented during DONE.
   logic [DATA_W-1:0]   cap_rdata;

   logic                misaligned;

   // Only word-aligned accesses reach the RAM.
   assign misaligned = (lat_addr[1:0] != 2'b00);

   assign busy      = (state != ST_IDLE);
   assign state_dbg = state;

   // --------------------------------------------------------------------------
   // Requester selection. Contention is resolved by the pointer; a lone
   // request always wins regardless of where the pointer points.
   // --------------------------------------------------------------------------
   always_comb begin
      grant_port = 1'b0;
      if (p0_req && p1_req) begin
         grant_port = ptr;
      end else if (p1_req) begin
         grant_port = 1'b1;
      end
   end

   // --------------------------------------------------------------------------
   // FSM state register
   // --------------------------------------------------------------------------
   always_ff @(posedge clk_in or negedge reset) begin
      if (!reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // --------------------------------------------------------------------------
   // FSM next state and outputs
   // --------------------------------------------------------------------------
   always_comb begin
      state_next  = state;
      grant_valid = 1'b0;

      ram_rena    = 1'b0;
      ram_wena    = 1'b0;
      ram_addr    = '0;
      ram_wdata   = '0;

      p0_done     = 1'b0;
      p0_err      = 1'b0;
      p0_rdata    = '0;
      p1_done     = 1'b0;
      p1_err      = 1'b0;
      p1_rdata    = '0;

      case (state)
         ST_IDLE: begin
            if (p0_req || p1_req) begin
               grant_valid = 1'b1;
               state_next  = ST_ACCESS;
            end
         end

         ST_ACCESS: begin
            // Address and data follow the latched command for the whole
            // cycle; the enables are suppressed for a misaligned address so
            // the RAM never sees the access.
            ram_addr   = lat_addr;
            ram_wdata  = lat_wdata;
            ram_wena   = lat_we && !misaligned;
            ram_rena   = !lat_we && !misaligned;
            state_next = ST_DONE;
         end

         ST_DONE: begin
            // Requests are not looked at here; a held request is picked up
            // in the following IDLE cycle.
            if (owner) begin
               p1_done  = 1'b1;
               p1_err   = misaligned;
               p1_rdata = cap_rdata;
            end else begin
               p0_done  = 1'b1;
               p0_err   = misaligned;
               p0_rdata = cap_rdata;
            end
            state_next = ST_IDLE;
         end

         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // --------------------------------------------------------------------------
   // Grant bookkeeping, command latch and read-data capture
   // --------------------------------------------------------------------------
   always_ff @(posedge clk_in or negedge reset) begin
      if (!reset) begin
         ptr       <= 1'b0;
         owner     <= 1'b0;
         lat_we    <= 1'b0;
         lat_addr  <= '0;
         lat_wdata <= '0;
         cap_rdata <= '0;
      end else begin
         if (grant_valid) begin
            owner     <= grant_port;
            lat_we    <= grant_port ? p1_we    : p0_we;
            lat_addr  <= grant_port ? p1_addr  : p0_addr;
            lat_wdata <= grant_port ? p1_wdata : p0_wdata;
            // Round-robin hands the next contention to the port that did
            // not get this grant, which bounds any wait to one transaction.
            if (FIXED_PRI != 0) begin
               ptr <= 1'b0;
            end else begin
               ptr <= ~grant_port;
            end
         end

         if (state == ST_ACCESS) begin
            // Writes and rejected accesses return zero data.
            if (!lat_we && !misaligned) begin
               cap_rdata <= ram_rdata;
            end else begin
               cap_rdata <= '0;
            end
         end
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
//
// Two arbiters share one set of requester inputs: dut_rr (round-robin) and
// dut_fp (fixed priority). Each has its own RAM model. A transaction-level
// model predicts, for each instance, which port is served, what reaches the
// RAM and what comes back; a compare process checks every output of both
// instances on every falling edge. Directed sequences add literal
// expectations (latencies, served counts, and an ordered done queue for
// dut_rr).
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

   localparam int AW   = 32;
   localparam int DW   = 32;
   localparam int SB_W = 2 + DW;   // {port, err, rdata}

   // ---------------------------------------------------------------- clock/reset
   logic clk_in = 1'b0;
   logic reset;
   always #5 clk_in = ~clk_in;

   // ---------------------------------------------------------------- stimulus
   logic          p0_req, p0_we, p1_req, p1_we;
   logic [AW-1:0] p0_addr, p1_addr;
   logic [DW-1:0] p0_wdata, p1_wdata;

   // ---------------------------------------------------------------- DUT outputs, index 0 = rr, 1 = fp
   logic [1:0]    o_p0_done, o_p1_done, o_p0_err, o_p1_err;
   logic [1:0]    o_rena, o_wena, o_busy, o_owner;
   logic [DW-1:0] o_p0_rdata [2];
   logic [DW-1:0] o_p1_rdata [2];
   logic [DW-1:0] o_ram_wdata [2];
   logic [DW-1:0] i_ram_rdata [2];
   logic [AW-1:0] o_ram_addr [2];
   logic [1:0]    o_state [2];

   dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIXED_PRI(0)) dut_rr (
      .clk_in(clk_in), .reset(reset),
      .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
      .p0_done(o_p0_done[0]), .p0_err(o_p0_err[0]), .p0_rdata(o_p0_rdata[0]),
      .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
      .p1_done(o_p1_done[0]), .p1_err(o_p1_err[0]), .p1_rdata(o_p1_rdata[0]),
      .ram_rena(o_rena[0]), .ram_wena(o_wena[0]), .ram_addr(o_ram_addr[0]),
      .ram_wdata(o_ram_wdata[0]), .ram_rdata(i_ram_rdata[0]),
      .busy(o_busy[0]), .owner(o_owner[0]), .state_dbg(o_state[0])
   );

   dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIXED_PRI(1)) dut_fp (
      .clk_in(clk_in), .reset(reset),
      .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
      .p0_done(o_p0_done[1]), .p0_err(o_p0_err[1]), .p0_rdata(o_p0_rdata[1]),
      .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
      .p1_done(o_p1_done[1]), .p1_err(o_p1_err[1]), .p1_rdata(o_p1_rdata[1]),
      .ram_rena(o_rena[1]), .ram_wena(o_wena[1]), .ram_addr(o_ram_addr[1]),
      .ram_wdata(o_ram_wdata[1]), .ram_rdata(i_ram_rdata[1]),
      .busy(o_busy[1]), .owner(o_owner[1]), .state_dbg(o_state[1])
   );

   // ---------------------------------------------------------------- RAM models
   // Unwritten words read back a recognisable pattern derived from the index.
   bit [DW-1:0] ram_val [2][256];
   bit          ram_wr  [2][256];

   function automatic logic [DW-1:0] pattern(input logic [7:0] idx);
      return 32'hA5A5_0000 | {24'h0, idx};
   endfunction

   function automatic logic [DW-1:0] ram_peek(input int k, input logic [7:0] idx);
      return ram_wr[k][idx] ? ram_val[k][idx] : pattern(idx);
   endfunction

   always_comb begin
      for (int k = 0; k < 2; k++) begin
         i_ram_rdata[k] = ram_peek(k, o_ram_addr[k][9:2]);
      end
   end

   always @(posedge clk_in) begin
      for (int k = 0; k < 2; k++) begin
         if (o_wena[k]) begin
            ram_val[k][o_ram_addr[k][9:2]] <= o_ram_wdata[k];
            ram_wr[k][o_ram_addr[k][9:2]]  <= 1'b1;
         end
      end
   end

   // ---------------------------------------------------------------- reference model
   // Per instance: cycles since the last grant (0 = nothing in flight,
   // 1 = RAM cycle, 2 = completion cycle), the transaction being served,
   // which port wins the next tie, and the model's own view of memory.
   int            m_t     [2];
   logic          m_port  [2];
   logic          m_owner [2];
   logic          m_pref  [2];
   logic          m_we    [2];
   logic [AW-1:0] m_addr  [2];
   logic [DW-1:0] m_wdata [2];
   logic [DW-1:0] m_rdata [2];
   bit   [DW-1:0] m_mem   [2][256];
   bit            m_mwr   [2][256];

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_t[k] = 0;  m_port[k] = 1'b0; m_owner[k] = 1'b0; m_pref[k] = 1'b0;
         m_we[k] = 1'b0; m_addr[k] = '0; m_wdata[k] = '0; m_rdata[k] = '0;
      end
   endtask

   task automatic model_step();
      logic win;
      logic [7:0] idx;
      for (int k = 0; k < 2; k++) begin
         if (m_t[k] == 0) begin
            if (p0_req || p1_req) begin
               win        = (p0_req && p1_req) ? m_pref[k] : p1_req;
               m_port[k]  = win;
               m_owner[k] = win;
               m_we[k]    = win ? p1_we    : p0_we;
               m_addr[k]  = win ? p1_addr  : p0_addr;
               m_wdata[k] = win ? p1_wdata : p0_wdata;
               // instance 1 always prefers port 0; instance 0 prefers the loser
               m_pref[k]  = (k == 1) ? 1'b0 : !win;
               m_t[k]     = 1;
            end
         end else if (m_t[k] == 1) begin
            idx        = m_addr[k][9:2];
            m_rdata[k] = '0;
            if (m_addr[k][1:0] == 2'b00) begin
               if (m_we[k]) begin
                  m_mem[k][idx] = m_wdata[k];
                  m_mwr[k][idx] = 1'b1;
               end else begin
                  m_rdata[k] = m_mwr[k][idx] ? m_mem[k][idx] : pattern(idx);
               end
            end
            m_t[k] = 2;
         end else begin
            m_t[k] = 0;
         end
      end
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk_in or negedge reset);
         if (!reset) model_reset();
         else        model_step();
      end
   end

   // ---------------------------------------------------------------- scoreboard
   int checks = 0;
   int errors = 0;
   bit sb_en  = 1'b0;
   logic [SB_W-1:0] exp_q[$];

   task automatic chk(input string name, input int k, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s (dut%0d) at %0t: got 0x%0h, expected 0x%0h",
                  name, k, $time, act, exp);
      end
   endtask

   // Compare process: every output of both instances, every falling edge.
   initial begin
      logic misal, acc, dn;
      logic [SB_W-1:0] got, want;
      forever begin
         @(negedge clk_in);
         for (int k = 0; k < 2; k++) begin
            misal = (m_addr[k][1:0] != 2'b00);
            acc   = (m_t[k] == 1);
            dn    = (m_t[k] == 2);
            chk("busy",     k, o_busy[k],  m_t[k] != 0);
            chk("owner",    k, o_owner[k], m_owner[k]);
            chk("ram_rena", k, o_rena[k],  acc && !misal && !m_we[k]);
            chk("ram_wena", k, o_wena[k],  acc && !misal && m_we[k]);
            if (acc && !misal) chk("ram_addr", k, o_ram_addr[k], m_addr[k]);
            if (acc && !misal && m_we[k]) chk("ram_wdata", k, o_ram_wdata[k], m_wdata[k]);
            chk("p0_done",  k, o_p0_done[k], dn && !m_port[k]);
            chk("p0_err",   k, o_p0_err[k],  dn && !m_port[k] && misal);
            chk("p0_rdata", k, o_p0_rdata[k], (dn && !m_port[k]) ? m_rdata[k] : '0);
            chk("p1_done",  k, o_p1_done[k], dn && m_port[k]);
            chk("p1_err",   k, o_p1_err[k],  dn && m_port[k] && misal);
            chk("p1_rdata", k, o_p1_rdata[k], (dn && m_port[k]) ? m_rdata[k] : '0);
            if (!reset) begin
               chk("rst_ram_addr",  k, o_ram_addr[k],  '0);
               chk("rst_ram_wdata", k, o_ram_wdata[k], '0);
               chk("rst_state",     k, o_state[k],     '0);
            end
         end
         if (sb_en && (o_p0_done[0] || o_p1_done[0])) begin
            got = {o_p1_done[0],
                   o_p1_done[0] ? o_p1_err[0]   : o_p0_err[0],
                   o_p1_done[0] ? o_p1_rdata[0] : o_p0_rdata[0]};
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL sb_unexpected_done at %0t: got 0x%0h, expected none", $time, got);
            end else begin
               want = exp_q.pop_front();
               chk("sb_done", 0, got, want);
            end
         end
      end
   end

   // ---------------------------------------------------------------- driver tasks
   task automatic drive(input int p, input logic r, input logic we,
                        input logic [AW-1:0] a, input logic [DW-1:0] d);
      if (p == 0) begin p0_req = r; p0_we = we; p0_addr = a; p0_wdata = d; end
      else        begin p1_req = r; p1_we = we; p1_addr = a; p1_wdata = d; end
   endtask

   function automatic logic is_done(input int k, input int p);
      return (p == 0) ? o_p0_done[k] : o_p1_done[k];
   endfunction

   // Counts falling edges until port p of instance k signals done.
   task automatic wait_done(input int k, input int p, input int budget, output int lat);
      lat = 0;
      forever begin
         @(negedge clk_in);
         lat++;
         if (is_done(k, p)) break;
         if (lat >= budget) begin
            checks++;
            errors++;
            $display("FAIL wait_done dut%0d p%0d: no done within %0d cycles", k, p, budget);
            break;
         end
      end
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         @(negedge clk_in);
         #1;
         n++;
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL sb_drain: got %0d outstanding, expected 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic do_reset();
      @(negedge clk_in);
      #2 reset = 1'b0;
      repeat (2) @(negedge clk_in);
      #2 reset = 1'b1;
   endtask

   // ---------------------------------------------------------------- directed sequences
   initial begin
      int lat, c0, c1, c0_rr, c1_rr, first;
      reset = 1'b0;
      drive(0, 1'b0, 1'b0, '0, '0);
      drive(1, 1'b0, 1'b0, '0, '0);
      repeat (3) @(negedge clk_in);
      chk("reset_busy",  0, o_busy[0],  1'b0);
      chk("reset_owner", 1, o_owner[1], 1'b0);
      #2 reset = 1'b1;
      sb_en = 1'b1;

      // p0 write 0xDEADBEEF to 0x10, then read it back.
      @(negedge clk_in);
      drive(0, 1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF);
      exp_q.push_back({1'b0, 1'b0, 32'h0});
      @(negedge clk_in);
      chk("wr_wena", 0, o_wena[0], 1'b1);
      chk("wr_addr", 0, o_ram_addr[0], 32'h10);
      wait_done(0, 0, 4, lat);
      chk("wr_latency", 0, 1 + lat, 2);
      drive(0, 1'b1, 1'b0, 32'h10, 32'h0);
      exp_q.push_back({1'b0, 1'b0, 32'hDEAD_BEEF});
      wait_done(0, 0, 6, lat);
      chk("rd_latency", 0, lat, 3);
      chk("rd_data", 0, o_p0_rdata[0], 32'hDEAD_BEEF);
      drive(0, 1'b0, 1'b0, '0, '0);
      drain(6);

      // Both read together after reset. p1 retargets before its grant
      // (0x24 -> 0x28, honoured); p0 retargets after its grant (ignored for
      // the first read, becomes its next request). Order p0, p1, p0.
      do_reset();
      @(negedge clk_in);
      drive(0, 1'b1, 1'b0, 32'h20, '0);
      drive(1, 1'b1, 1'b0, 32'h24, '0);
      exp_q.push_back({1'b0, 1'b0, 32'hA5A5_0008});
      exp_q.push_back({1'b1, 1'b0, 32'hA5A5_000A});
      exp_q.push_back({1'b0, 1'b0, 32'hA5A5_000C});
      @(negedge clk_in);
      drive(0, 1'b1, 1'b0, 32'h30, '0);
      drive(1, 1'b1, 1'b0, 32'h28, '0);
      wait_done(0, 0, 4, lat);
      chk("rr_first_p0_latency", 0, 1 + lat, 2);
      wait_done(0, 1, 6, lat);
      chk("rr_p1_after_p0", 0, lat, 3);
      drive(1, 1'b0, 1'b0, '0, '0);
      wait_done(0, 0, 6, lat);
      chk("rr_p0_again", 0, lat, 3);
      drive(0, 1'b0, 1'b0, '0, '0);
      drain(6);

      // Misaligned p1 read: no RAM enable, err with done, zero data.
      @(negedge clk_in);
      drive(1, 1'b1, 1'b0, 32'h13, '0);
      exp_q.push_back({1'b1, 1'b1, 32'h0});
      @(negedge clk_in);
      chk("mis_rena", 0, o_rena[0], 1'b0);
      chk("mis_wena", 0, o_wena[0], 1'b0);
      wait_done(0, 1, 4, lat);
      chk("mis_err",   0, o_p1_err[0],   1'b1);
      chk("mis_rdata", 0, o_p1_rdata[0], 32'h0);
      drive(1, 1'b0, 1'b0, '0, '0);
      drain(6);

      // Reset in the middle of a p0 write: write aborted, no done.
      @(negedge clk_in);
      drive(0, 1'b1, 1'b1, 32'h40, 32'h1234_5678);
      @(posedge clk_in);
      #1 chk("pre_abort_wena", 0, o_wena[0], 1'b1);
      #1 reset = 1'b0;
      #1;
      chk("abort_wena_rr", 0, o_wena[0], 1'b0);
      chk("abort_wena_fp", 1, o_wena[1], 1'b0);
      chk("abort_busy",    0, o_busy[0], 1'b0);
      drive(0, 1'b0, 1'b0, '0, '0);
      c0 = 0;
      repeat (3) begin
         @(negedge clk_in);
         if (o_p0_done[0]) c0++;
      end
      chk("abort_no_done", 0, c0, 0);
      @(negedge clk_in);
      #2 reset = 1'b1;
      chk("abort_ram_kept", 0, ram_peek(0, 8'h10), 32'hA5A5_0010);
      @(negedge clk_in);
      drive(0, 1'b1, 1'b0, 32'h40, '0);
      exp_q.push_back({1'b0, 1'b0, 32'hA5A5_0010});
      wait_done(0, 0, 4, lat);
      chk("post_reset_latency", 0, lat, 2);
      drive(0, 1'b0, 1'b0, '0, '0);
      drain(6);

      // p1 read held for 9 cycles alone: one done every 3 cycles.
      @(negedge clk_in);
      drive(1, 1'b1, 1'b0, 32'h08, '0);
      repeat (3) exp_q.push_back({1'b1, 1'b0, 32'hA5A5_0002});
      c1 = 0;
      for (int i = 0; i < 9; i++) begin
         @(negedge clk_in);
         if (o_p1_done[0]) c1++;
      end
      drive(1, 1'b0, 1'b0, '0, '0);
      chk("hold_p1_dones", 0, c1, 3);
      drain(6);

      // Both held: fixed priority serves only p0; round-robin alternates.
      sb_en = 1'b0;
      do_reset();
      @(negedge clk_in);
      drive(0, 1'b1, 1'b0, 32'h00, '0);
      drive(1, 1'b1, 1'b0, 32'h04, '0);
      c0 = 0; c1 = 0; c0_rr = 0; c1_rr = 0; first = 0;
      for (int i = 1; i <= 9; i++) begin
         @(negedge clk_in);
         if (o_p0_done[1]) begin
            c0++;
            if (first == 0) first = i;
         end
         if (o_p1_done[1]) c1++;
         if (o_p0_done[0]) c0_rr++;
         if (o_p1_done[0]) c1_rr++;
      end
      chk("fp_first_done", 1, first, 2);
      chk("fp_p0_dones",   1, c0, 3);
      chk("fp_p1_dones",   1, c1, 0);
      chk("rr_p0_dones",   0, c0_rr, 2);
      chk("rr_p1_dones",   0, c1_rr, 1);
      drive(0, 1'b0, 1'b0, '0, '0);
      wait_done(1, 1, 4, lat);
      chk("fp_p1_after_drop", 1, lat, 2);
      chk("fp_p1_rdata", 1, o_p1_rdata[1], 32'hA5A5_0001);
      drive(1, 1'b0, 1'b0, '0, '0);

      repeat (3) @(negedge clk_in);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete within 100000 time units");
      $fatal(1);
   end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter: ADDR_W, default 32, byte-address width of requester and RAM address buses.
REQ-002 Parameter: DATA_W, default 32, data width of all write/read buses.
REQ-003 Parameter: FIXED_PRI, default 0; 0 = round-robin, 1 = port 0 always wins contention.
REQ-004 One clock; reset is asynchronous and active-low.
REQ-005 clk_in  input  1  system clock; all state changes on rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 p0_req / p1_req  input  1  access request, level, held until done.
REQ-008 p0_we / p1_we  input  1  1 = write, 0 = read; held with req.
REQ-009 p0_addr / p1_addr  input  ADDR_W  byte address; held with req.
REQ-010 p0_wdata / p1_wdata  input  DATA_W  write data; held with req.
REQ-011 p0_done / p1_done  output  1  one-cycle completion pulse for that port.
REQ-012 p0_err / p1_err  output  1  one-cycle misalignment error, coincident with done.
REQ-013 p0_rdata / p1_rdata  output  DATA_W  read data, valid while done high.
REQ-014 ram_rena / ram_wena  output  1  RAM read/write enables.
REQ-015 ram_addr  output  ADDR_W  RAM address; ram_wdata  output  DATA_W  RAM write data.
REQ-016 ram_rdata  input  DATA_W  RAM combinational read data.
REQ-017 busy  output  1  high when state is not IDLE; owner  output  1  port currently granted.

Function
REQ-018 FSM states SHALL be IDLE, ACCESS, DONE; IDLE->ACCESS when any req high; ACCESS->DONE always; DONE->IDLE always.
REQ-019 In IDLE, single req: that port granted; both req: port indicated by priority pointer granted.
REQ-020 Priority pointer SHALL reset to port 0; in round-robin mode it SHALL point to the non-granted port after every grant.
REQ-021 With FIXED_PRI=1, pointer SHALL be held at port 0.
REQ-022 On IDLE->ACCESS edge, granted port's we, addr, wdata SHALL be latched and owner updated.
REQ-023 In ACCESS only, ram_addr/ram_wdata SHALL drive latched values; ram_wena = latched we, ram_rena = !latched we.
REQ-024 ram_wena and ram_rena SHALL be 0 in IDLE and DONE.
REQ-025 At end of ACCESS, ram_rdata SHALL be captured for reads; capture register holds 0 for writes.
REQ-026 In DONE, owner's done SHALL be 1 and its rdata the captured value; other port's done/err/rdata SHALL be 0.
REQ-027 Latency: req sampled in IDLE at cycle N -> RAM access cycle N+1 -> done cycle N+2; one transaction per 3 cycles max.
REQ-028 Requester SHALL deassert req (or change to next request) in the cycle after done; req is ignored in DONE.
REQ-029 Latched addr[1:0] != 0: no RAM enable in ACCESS, err=1 and done=1 in DONE, rdata=0.
REQ-030 Pending loser's req SHALL be served in the next IDLE cycle (no starvation in round-robin: max wait one transaction).
REQ-031 Requester changing addr/wdata while req high and not yet granted SHALL take effect; changes after grant are ignored.

Reset
REQ-032 reset low SHALL immediately force state IDLE, pointer to port 0, owner 0, latches and capture register 0.
REQ-033 During and after reset all outputs SHALL be 0, including ram_wena mid-ACCESS (write aborted, no done pulse).

Verification
REQ-034 p0 write addr 0x10 data 0xDEADBEEF, then p0 read 0x10 -> ram_wena one cycle, then p0_done with p0_rdata 0xDEADBEEF at N+2.
REQ-035 p0 and p1 reads asserted same cycle after reset, FIXED_PRI=0 -> p0 done first, p1 done 3 cycles later; repeat -> p1 first.
REQ-036 FIXED_PRI=1, both ports request continuously -> p0 served every 3 cycles, p1 only when p0_req low.
REQ-037 p1 read addr 0x13 -> ram_rena/ram_wena stay 0, p1_done=1, p1_err=1, p1_rdata=0.
REQ-038 reset low during ACCESS of p0 write -> ram_wena drops same cycle, no p0_done, busy=0, next request granted normally.
REQ-039 Single p1 request held for 10 cycles with no p0 activity -> grant, done after 2 cycles, ram idle in DONE, p1_done pulses per transaction.
